// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile writeback controller.
// Optional round-robin arbitration is enabled with REGFILE_WB_RR_EN.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic SRC_ALU  = 1'b0;
  localparam logic SRC_LOAD = 1'b1;

  localparam logic [AW-1:0] ZERO_REG = '0;

  // A register being written this cycle is forwarded, so it is not a hazard.
  function automatic logic eff_busy(
    input logic [NREG-1:0] busy,
    input logic            we,
    input logic [AW-1:0]   wa,
    input logic [AW-1:0]   a
  );
    return busy[a] & ~(we & (wa == a));
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard; produces the decode stall.
// Shared by both arbitration modes (REGFILE_WB_RR_EN).
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          issue_valid,
  input  logic          issue_wb,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] rs1_addr,
  input  logic          rs1_use,
  input  logic [AW-1:0] rs2_addr,
  input  logic          rs2_use,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  output logic          stall
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            rs1_hz;
  logic            rs2_hz;
  logic            rd_hz;
  logic            issue_fire;

  always_comb begin
    rs1_hz = rs1_use & eff_busy(busy_q, wr_en, wr_addr, rs1_addr);
    rs2_hz = rs2_use & eff_busy(busy_q, wr_en, wr_addr, rs2_addr);
    rd_hz  = issue_valid & issue_wb
           & eff_busy(busy_q, wr_en, wr_addr, issue_rd);
    stall  = rs1_hz | rs2_hz | rd_hz;

    issue_fire = issue_valid & ~stall & issue_wb
               & (issue_rd != ZERO_REG) & ~flush;

    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    // Set after clear: a new producer owns the register.
    if (issue_fire) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-port arbiter (ALU vs load) with hazard scoreboard.
// REGFILE_WB_RR_EN selects round-robin on conflict; default is load priority.
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s0_valid,
  input  logic [AW-1:0]   s0_rd,
  input  logic [XLEN-1:0] s0_data,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic [AW-1:0]   s1_rd,
  input  logic [XLEN-1:0] s1_data,
  output logic            s1_ready,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] w_data,
  output logic            w_en,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wb,
  input  logic [AW-1:0]   rs1_addr,
  input  logic            rs1_use,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs2_use,
  input  logic            flush,
  output logic            stall
);

  logic            gnt0;
  logic            gnt1;
  logic            contend;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            w_en_q, w_en_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;

`ifdef REGFILE_WB_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  always_comb begin
    contend = s0_valid & s1_valid;
    gnt0    = s0_valid & ~s1_valid;
    gnt1    = s1_valid & ~s0_valid;
    if (contend) begin
`ifdef REGFILE_WB_RR_EN
      gnt1 = (last_grant_q == SRC_ALU);
      gnt0 = ~gnt1;
`else
      gnt1 = 1'b1;
`endif
    end
  end

  always_comb begin
    sel_rd   = gnt1 ? s1_rd : s0_rd;
    sel_data = gnt1 ? s1_data : s0_data;
    w_en_d   = (gnt0 | gnt1) & (sel_rd != ZERO_REG);
    rd_addr_d = w_en_d ? sel_rd : rd_addr_q;
    w_data_d  = w_en_d ? sel_data : w_data_q;
`ifdef REGFILE_WB_RR_EN
    last_grant_d = last_grant_q;
    if (contend) last_grant_d = gnt1 ? SRC_LOAD : SRC_ALU;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_en_q    <= 1'b0;
      rd_addr_q <= '0;
      w_data_q  <= '0;
    end else begin
      w_en_q    <= w_en_d;
      rd_addr_q <= rd_addr_d;
      w_data_q  <= w_data_d;
    end
  end

`ifdef REGFILE_WB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= SRC_ALU;
    else        last_grant_q <= last_grant_d;
  end
`endif

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;
  assign w_en     = w_en_q;
  assign rd_addr  = rd_addr_q;
  assign w_data   = w_data_q;

  wb_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_wb    (issue_wb),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs1_use     (rs1_use),
    .rs2_addr    (rs2_addr),
    .rs2_use     (rs2_use),
    .wr_en       (w_en_q),
    .wr_addr     (rd_addr_q),
    .stall       (stall)
  );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic
// against a behavioural model of the write port and scoreboard.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_valid, s1_valid;
  logic [4:0]  s0_rd, s1_rd;
  logic [31:0] s0_data, s1_data;
  logic        s0_ready, s1_ready;
  logic [4:0]  rd_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic        issue_valid, issue_wb;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_use, rs2_use;
  logic        flush;
  logic        stall;

  int total = 0;
  int bad = 0;

  bit          m_busy [32];
  bit          m_wen;
  bit [4:0]    m_rd;
  bit [31:0]   m_data;
  bit          m_last;
  bit          e_g0, e_g1, e_stall;
  bit          acc0, acc1;

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data),
    .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data),
    .s1_ready(s1_ready),
    .rd_addr(rd_addr), .w_data(w_data), .w_en(w_en),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_wb(issue_wb),
    .rs1_addr(rs1_addr), .rs1_use(rs1_use),
    .rs2_addr(rs2_addr), .rs2_use(rs2_use),
    .flush(flush), .stall(stall)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit eb(input bit [4:0] r);
    return (r != 0) && m_busy[r] && !(m_wen && m_rd == r);
  endfunction

  task automatic model_comb();
    e_g0 = 0;
    e_g1 = 0;
    if (s0_valid && s1_valid) begin
`ifdef REGFILE_WB_RR_EN
      if (m_last) e_g0 = 1;
      else        e_g1 = 1;
`else
      e_g1 = 1;
`endif
    end else begin
      e_g0 = s0_valid;
      e_g1 = s1_valid;
    end
    e_stall = (rs1_use && eb(rs1_addr)) || (rs2_use && eb(rs2_addr))
           || (issue_valid && issue_wb && eb(issue_rd));
  endtask

  task automatic model_seq();
    bit       fire;
    bit [4:0] srd;
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_wen = 0; m_rd = 0; m_data = 0; m_last = 0;
      return;
    end
    fire = issue_valid && !e_stall && issue_wb && issue_rd != 0 && !flush;
    if (flush) foreach (m_busy[i]) m_busy[i] = 0;
    else begin
      if (m_wen) m_busy[m_rd] = 0;
      if (fire) m_busy[issue_rd] = 1;
    end
    if (s0_valid && s1_valid) m_last = e_g1;
    srd = e_g1 ? s1_rd : s0_rd;
    m_wen = (e_g0 || e_g1) && srd != 0;
    if (m_wen) begin
      m_rd = srd;
      m_data = e_g1 ? s1_data : s0_data;
    end
  endtask

  task automatic tick();
    #1;
    model_comb();
    chk("s0_ready", s0_ready, e_g0);
    chk("s1_ready", s1_ready, e_g1);
    chk("stall", stall, e_stall);
    chk("w_en", w_en, m_wen);
    if (m_wen) begin
      chk("rd_addr", rd_addr, m_rd);
      chk("w_data", w_data, m_data);
    end
    acc0 = s0_valid && e_g0;
    acc1 = s1_valid && e_g1;
    @(posedge clk);
    model_seq();
    #1;
  endtask

  initial begin
    rst_n = 0; flush = 0;
    s0_valid = 1; s0_rd = 5; s0_data = 32'h1234;
    s1_valid = 0; s1_rd = 0; s1_data = 0;
    issue_valid = 0; issue_wb = 0; issue_rd = 0;
    rs1_addr = 0; rs1_use = 0; rs2_addr = 0; rs2_use = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_wen = 0; m_rd = 0; m_data = 0; m_last = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_en", w_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1; s0_data = 32'hDEADBEEF;
    tick();
    s0_valid = 0;
    #1;
    chk("first_w_en", w_en, 1);
    chk("first_rd", rd_addr, 5);
    chk("first_data", w_data, 32'hDEADBEEF);
    tick();

    s0_valid = 1; s0_rd = 3; s0_data = 32'h11;
    s1_valid = 1; s1_rd = 4; s1_data = 32'h22;
    #1;
    chk("cf_s1_ready", s1_ready, 1);
    chk("cf_s0_ready", s0_ready, 0);
    tick();
    s1_valid = 0;
    #1;
    chk("cf_rd_first", rd_addr, 4);
    chk("cf_data_first", w_data, 32'h22);
    tick();
    s0_valid = 0;
    #1;
    chk("cf_rd_second", rd_addr, 3);
    chk("cf_data_second", w_data, 32'h11);
    s0_valid = 1; s0_rd = 10; s0_data = 32'h33;
    s1_valid = 1; s1_rd = 11; s1_data = 32'h44;
    #1;
`ifdef REGFILE_WB_RR_EN
    chk("cf2_s0_ready", s0_ready, 1);
`else
    chk("cf2_s1_ready", s1_ready, 1);
`endif
    tick();
    if (acc0) s0_valid = 0;
    if (acc1) s1_valid = 0;
    tick();
    s0_valid = 0; s1_valid = 0;
    tick();

    issue_valid = 1; issue_wb = 1; issue_rd = 7;
    tick();
    issue_valid = 0; rs1_addr = 7; rs1_use = 1;
    #1;
    chk("raw_stall", stall, 1);
    tick();
    tick();
    s0_valid = 1; s0_rd = 7; s0_data = 32'h77;
    tick();
    s0_valid = 0;
    #1;
    chk("raw_wb_w_en", w_en, 1);
    chk("raw_bypass", stall, 0);
    tick();
    #1;
    chk("raw_cleared", stall, 0);
    rs1_use = 0;

    issue_valid = 1; issue_wb = 1; issue_rd = 9;
    tick();
    #1;
    chk("waw_stall", stall, 1);
    tick();
    s0_valid = 1; s0_rd = 9; s0_data = 32'h99;
    tick();
    s0_valid = 0;
    #1;
    chk("waw_land_stall", stall, 0);
    tick();
    issue_valid = 0; rs1_addr = 9; rs1_use = 1;
    #1;
    chk("set_wins", stall, 1);
    rs1_use = 0;

    s0_valid = 1; s0_rd = 0; s0_data = 32'hFFFF;
    #1;
    chk("x0_ready", s0_ready, 1);
    tick();
    s0_valid = 0;
    #1;
    chk("x0_no_w_en", w_en, 0);
    issue_valid = 1; issue_wb = 1; issue_rd = 0;
    #1;
    chk("x0_issue_stall", stall, 0);
    tick();
    issue_valid = 0; rs1_addr = 0; rs1_use = 1;
    #1;
    chk("x0_rs1_stall", stall, 0);
    rs1_use = 0;

    issue_valid = 1; issue_wb = 1; issue_rd = 2;
    tick();
    issue_rd = 6;
    tick();
    issue_valid = 0;
    s1_valid = 1; s1_rd = 2; s1_data = 32'h55; flush = 1;
    tick();
    s1_valid = 0; flush = 0;
    #1;
    chk("fl_w_en", w_en, 1);
    chk("fl_rd", rd_addr, 2);
    rs1_addr = 6; rs1_use = 1;
    #1;
    chk("fl_rs6", stall, 0);
    rs1_addr = 9;
    #1;
    chk("fl_rs9", stall, 0);
    tick();
    rs1_use = 0;

    s0_valid = 0; s1_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(s0_valid && !acc0)) begin
        s0_valid = ($urandom_range(0, 2) != 0);
        s0_rd = 5'($urandom_range(0, 7));
        s0_data = $urandom;
      end
      if (!(s1_valid && !acc1)) begin
        s1_valid = ($urandom_range(0, 2) != 0);
        s1_rd = 5'($urandom_range(0, 7));
        s1_data = $urandom;
      end
      rst_n = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 19) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_wb = ($urandom_range(0, 3) != 0);
      issue_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs1_use = $urandom_range(0, 1) == 1;
      rs2_addr = 5'($urandom_range(0, 7));
      rs2_use = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
